// File: rtl/pipe_ctrl_seq.sv
// N-stage control-word pipeline for RNBIP-2: carries opcode/ctrl per instruction,
// resolves conditionals at RES_STAGE, flushes younger entries on a taken PC load, stalls on load-use.
module pipe_ctrl_seq #(
    parameter int unsigned OW        = 8,
    parameter int unsigned CW        = 18,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned RES_STAGE = 1,
    parameter int unsigned RD_BIT    = 17,
    parameter int unsigned RN_BIT    = 14,
    parameter int unsigned PC_BIT    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OW-1:0]        in_opcode,
    input  logic [CW-1:0]        in_ctrl,
    input  logic                 in_cond,
    input  logic                 in_uses_rn,
    input  logic                 flag_in,
    output logic [STAGES-1:0]    stage_valid,
    output logic [STAGES*OW-1:0] stage_opcode,
    output logic [STAGES*CW-1:0] stage_ctrl,
    output logic                 flush,
    output logic                 stall,
    output logic [15:0]          squash_count
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_cond;
    logic [OW-1:0]     r_opcode [STAGES];
    logic [CW-1:0]     r_ctrl   [STAGES];

    logic          w_squash;
    logic [CW-1:0] w_eff_ctrl;
    logic          w_accept;

    // Conditional resolution and hazard/accept decisions are purely combinational.
    always_comb begin
        w_squash   = r_valid[RES_STAGE] && r_cond[RES_STAGE] && !flag_in;
        w_eff_ctrl = w_squash ? '0 : r_ctrl[RES_STAGE];
        flush      = !rst && r_valid[RES_STAGE] && w_eff_ctrl[PC_BIT];
        stall      = !rst && r_valid[0] && r_ctrl[0][RD_BIT] && r_ctrl[0][RN_BIT]
                     && in_valid && in_uses_rn && !flush;
        in_ready   = !rst && !stall && !flush;
        w_accept   = in_valid && in_ready;
    end

    // Invalid stages present all-zero opcode/ctrl; RES_STAGE shows the resolved word.
    always_comb begin
        stage_valid  = '0;
        stage_opcode = '0;
        stage_ctrl   = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_valid[i] = r_valid[i];
            if (r_valid[i]) begin
                stage_opcode[i*OW +: OW] = r_opcode[i];
                stage_ctrl[i*CW +: CW]   = (i == RES_STAGE) ? w_eff_ctrl : r_ctrl[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_cond       <= '0;
            squash_count <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_opcode[i] <= '0;
                r_ctrl[i]   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_valid[0]  <= 1'b1;
                r_opcode[0] <= in_opcode;
                r_ctrl[0]   <= in_ctrl;
                r_cond[0]   <= in_cond;
            end else begin
                r_valid[0]  <= 1'b0;
                r_opcode[0] <= '0;
                r_ctrl[0]   <= '0;
                r_cond[0]   <= 1'b0;
            end
            // Entries younger than the taken PC load are dropped while advancing.
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (flush && i <= RES_STAGE) begin
                    r_valid[i]  <= 1'b0;
                    r_opcode[i] <= '0;
                    r_ctrl[i]   <= '0;
                    r_cond[i]   <= 1'b0;
                end else if (i - 1 == RES_STAGE) begin
                    r_valid[i]  <= r_valid[i-1];
                    r_opcode[i] <= r_opcode[i-1];
                    r_ctrl[i]   <= w_eff_ctrl;
                    r_cond[i]   <= 1'b0;
                end else begin
                    r_valid[i]  <= r_valid[i-1];
                    r_opcode[i] <= r_opcode[i-1];
                    r_ctrl[i]   <= r_ctrl[i-1];
                    r_cond[i]   <= r_cond[i-1];
                end
            end
            if (w_squash && squash_count != 16'hFFFF)
                squash_count <= squash_count + 16'd1;
        end
    end

endmodule

// File: doc/pipe_ctrl_seq.md
# pipe_ctrl_seq

Parametrised pipeline control sequencer for the RNBIP-2 processor. It generalises the single registered opcode/flag stage into an N-stage control-word pipeline. It takes a decoded control word per instruction and carries it, with its opcode, through `STAGES` registered stages. Along the way it resolves conditional instructions against the flag, flushes younger stages on a taken PC load, and inserts a one-cycle stall on load-use hazards.

## Interface
Parameters:
- `OW`, 8, opcode width.
- `CW`, 18, control word width; layout {RD,WR,L_R0,L_RN,S_AL,I_SP,D_SP,L_PC,S11,S10,S20,S30,S40,S50,S60,S82,S81,S80}, MSB first.
- `STAGES`, 3, pipeline depth, ≥2.
- `RES_STAGE`, 1, stage index where conditions resolve; 0 ≤ RES_STAGE < STAGES.
- `RD_BIT`, 17, bit position of RD.
- `RN_BIT`, 14, bit position of L_RN.
- `PC_BIT`, 10, bit position of L_PC.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream instruction present.
- `in_ready`  out  1  block accepts this cycle.
- `in_opcode`  in  OW  opcode.
- `in_ctrl`  in  CW  decoded control word.
- `in_cond`  in  1  instruction is flag-conditional.
- `in_uses_rn`  in  1  instruction reads a register-array operand.
- `flag_in`  in  1  selected condition flag for the entry at RES_STAGE.
- `stage_valid`  out  STAGES  valid bit per stage.
- `stage_opcode`  out  STAGES*OW  opcode per stage; stage i at [i*OW +: OW].
- `stage_ctrl`  out  STAGES*CW  effective control word per stage.
- `flush`  out  1  taken PC load at RES_STAGE this cycle.
- `stall`  out  1  load-use hazard this cycle.
- `squash_count`  out  16  count of conditional instructions squashed.

## Operation
- Each stage i holds valid, opcode, ctrl and cond. On every edge, stage i loads from stage i-1 (i≥1). Stage 0 loads the input when accepted, else a bubble (valid=0, opcode=0, ctrl=0, cond=0).
- Accept condition: `in_ready = !rst && !stall && !flush`. An accept occurs when in_valid && in_ready.
- Output masking: `stage_ctrl` and `stage_opcode` are 0 for any invalid stage.
- Conditional resolution happens at RES_STAGE, combinationally.
  - Effective ctrl is 0 when valid && cond && !flag_in; otherwise it is the stored ctrl.
  - The effective value is both output and propagated to RES_STAGE+1, with cond cleared.
  - Each squash increments squash_count, saturating at 0xFFFF.
- Flush: `flush = valid[RES_STAGE] && effective_ctrl[PC_BIT]`.
  - At the next edge, stages 0..RES_STAGE-1 become bubbles.
  - No input is accepted that cycle.
  - Stage RES_STAGE itself propagates normally.
- Stall: `stall = valid[0] && ctrl0[RD_BIT] && ctrl0[RN_BIT] && in_valid && in_uses_rn && !flush`.
  - Stage 0 advances, and a bubble enters stage 0.
  - The input is held and accepted on the following cycle, so a stall lasts exactly one cycle.
- Priority: reset > flush > stall > normal advance.
- Reset:
  - All stage valid, opcode, ctrl and cond registers, and squash_count, go to 0 at the edge where rst=1.
  - While rst=1, flush=0, stall=0 and in_ready=0.
  - The first accept is possible in the cycle after rst falls.

## Timing
- Instruction accepted at edge N is in stage k after edge N+k, i.e. visible at stage k during cycle N+k+1 minus one. Stage 0 is visible right after edge N.
- Throughput: one instruction per cycle absent stall/flush.
- flush, stall and in_ready are combinational from current stage state and inputs. They have no register delay.
- A flush removes exactly RES_STAGE younger entries plus the rejected input. With RES_STAGE=0 it removes only the input.
- A squashed entry keeps valid=1 through later stages with ctrl=0; opcode is retained for trace.
- squash_count updates on the edge following the squash cycle.
- Simultaneous squash and PC bit: a squashed word has ctrl=0, so no flush occurs.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with in_valid=1.
  - Required response: stage_valid=000, all stage_ctrl=0, in_ready=0, squash_count=0. After release, in_ready=1.
- Streaming:
  - Stimulus: ctrl 0x00001, 0x00002, 0x00003 on consecutive cycles, cond=0.
  - Required response: each appears in stage 0 after accept and in stage 2 two edges later. stall and flush stay 0.
- Squash:
  - Stimulus: ctrl 0x00401, cond=1, flag_in=0 while at stage 1.
  - Required response: stage_ctrl[1]=0 and flush=0. Stage 2 shows ctrl 0 with valid=1 next cycle. squash_count becomes 1.
- Taken:
  - Stimulus: same entry with flag_in=1.
  - Required response: flush=1 for one cycle and in_ready=0. The stage 0 entry is bubbled next edge. Stage 2 shows 0x00401.
- Load-use:
  - Stimulus: stage 0 ctrl 0x24000, with in_valid=1 and in_uses_rn=1.
  - Required response: stall=1 and in_ready=0 for exactly one cycle. A bubble appears in stage 0, and the input is accepted the next cycle.
- Mid-run reset:
  - Stimulus: three valid entries and squash_count=5, then rst=1 for one cycle.
  - Required response: all stages invalid and squash_count=0 after that edge.
